// File: rtl/heartbeat_monitor_if.sv
// -----------------------------------------------------------------------------
// heartbeat_monitor_if
//   Groups the heartbeat pin and the health outputs of one CPU.
//   master : drives pwm, observes the health outputs (CPU side / test side)
//   slave  : the heartbeat_monitor itself
//
//   Signals:
//     pwm          raw heartbeat pin (asynchronous to clk)
//     io           1 = CPU healthy, 0 = failed or not yet acquired
//     lost_pulse   one-clk strobe on every 1->0 transition of io
//     period       last measured edge-to-edge period in clk cycles
//     period_valid one-clk strobe marking an update of period
//
//   Handshake: period_valid is a pure valid-only qualifier. period holds its
//   value between strobes and there is no ready/backpressure; a consumer that
//   cares must capture period in the cycle period_valid is high.
// -----------------------------------------------------------------------------
interface heartbeat_monitor_if #(
   parameter int CNT_W = 24
);
   logic             pwm;
   logic             io;
   logic             lost_pulse;
   logic [CNT_W-1:0] period;
   logic             period_valid;

   modport master (
      output pwm,
      input  io,
      input  lost_pulse,
      input  period,
      input  period_valid
   );

   modport slave (
      input  pwm,
      output io,
      output lost_pulse,
      output period,
      output period_valid
   );
endinterface

// File: rtl/heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// heartbeat_monitor
//   Qualifies one CPU heartbeat pin by edge-to-edge period measurement and
//   drives the per-CPU health level io, with acquire/lose hysteresis.
//
//   Ports:
//     clk      system clock
//     rst_n    asynchronous active-low reset
//     hb       heartbeat_monitor_if.slave (pwm in; io, lost_pulse, period,
//              period_valid out)
//     state_o  current FSM state (debug visibility): 0 LOST, 1 ACQUIRE,
//              2 HEALTHY, 3 SUSPECT
//
//   Pipeline: pwm -> sync1 -> sync2 -> prev, and a registered rise flag
//   (edge_q) that is high in the 3rd clk after the pin rises. Counter, period,
//   FSM and io all update on the clk that consumes edge_q.
//
//   Optional build macro: HB_DUTY_CHECK_EN adds a high-time check; a period is
//   then good only if the preceding high time was at least MIN_HIGH clk.
// -----------------------------------------------------------------------------
module heartbeat_monitor #(
   parameter int CNT_W      = 24,
   parameter int MIN_PERIOD = 90,
   parameter int MAX_PERIOD = 110,
   parameter int GOOD_CNT   = 3,
   parameter int BAD_CNT    = 2,
   parameter int MIN_HIGH   = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   heartbeat_monitor_if.slave     hb,
   output logic [1:0]             state_o
);

   localparam int RUN_MAX = (GOOD_CNT > BAD_CNT) ? GOOD_CNT : BAD_CNT;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);

   localparam logic [CNT_W-1:0] TMO     = CNT_W'(MAX_PERIOD + 1);
   localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [RUN_W-1:0] GOOD_N  = RUN_W'(GOOD_CNT);
   localparam logic [RUN_W-1:0] BAD_N   = RUN_W'(BAD_CNT);

   // Elaboration-time parameter sanity: the timeout value must be
   // representable, and a negative high-time threshold is meaningless.
   if (MAX_PERIOD + 1 >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("heartbeat_monitor: MAX_PERIOD+1 does not fit in CNT_W");
   end
   if (MIN_HIGH < 0) begin : g_bad_min_high
      $error("heartbeat_monitor: MIN_HIGH must be non-negative");
   end

   typedef enum logic [1:0] {
      ST_LOST    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_HEALTHY = 2'd2,
      ST_SUSPECT = 2'd3
   } state_e;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q,  prev_d;
   logic             edge_q,  edge_d;
   logic             ref_q,   ref_d;     // a reference edge is held
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             pvalid_q, pvalid_d;
   state_e           state_q, state_d;
   logic [RUN_W-1:0] good_q,  good_d;
   logic [RUN_W-1:0] bad_q,   bad_d;
   logic             io_q,    io_d;
   logic             lost_q,  lost_d;

   logic             judge;      // edge with a valid reference: period gets judged
   logic             timeout;    // counter hit MAX_PERIOD+1 without an edge
   logic             win_ok;
   logic             period_good;

   assign judge   = edge_q & ref_q;
   // An edge in the same clk as the saturation value wins over the timeout.
   assign timeout = ref_q & ~edge_q & (cnt_q == TMO);
   assign win_ok  = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);

`ifdef HB_DUTY_CHECK_EN
   // High time of the most recent pulse, counted on the prev_q stage so it is
   // aligned with edge_q. It saturates at MIN_HIGH since only ">= MIN_HIGH"
   // matters, and it restarts at 1 on each rise (the rise clk is already high).
   localparam logic [CNT_W-1:0] H_MIN = CNT_W'(MIN_HIGH);
   logic [CNT_W-1:0] high_q, high_d;

   always_comb begin
      high_d = high_q;
      if (edge_q) begin
         high_d = CNT_ONE;
      end else if (prev_q && (high_q < H_MIN)) begin
         high_d = high_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_q <= '0;
      end else begin
         high_q <= high_d;
      end
   end

   assign period_good = win_ok && (high_q >= H_MIN);
`else
   assign period_good = win_ok;
`endif

   always_comb begin
      // Defaults: synchronizer chain shifts, everything else holds.
      sync1_d  = hb.pwm;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      edge_d   = sync2_q & ~prev_q;
      ref_d    = ref_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      pvalid_d = 1'b0;
      state_d  = state_q;
      good_d   = good_q;
      bad_d    = bad_q;

      // Period counter and reference tracking.
      if (edge_q) begin
         ref_d = 1'b1;
         cnt_d = CNT_ONE;
         if (ref_q) begin
            period_d = cnt_q;
            pvalid_d = 1'b1;
         end
      end else if (timeout) begin
         ref_d = 1'b0;
         cnt_d = '0;
      end else if (ref_q && (cnt_q != TMO)) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      // Health FSM.
      if (timeout) begin
         state_d = ST_LOST;
         good_d  = '0;
         bad_d   = '0;
      end else if (judge) begin
         unique case (state_q)
            ST_LOST: begin
               if (period_good) begin
                  if (GOOD_CNT == 1) begin
                     state_d = ST_HEALTHY;
                     good_d  = '0;
                  end else begin
                     state_d = ST_ACQUIRE;
                     good_d  = RUN_ONE;
                  end
               end
            end
            ST_ACQUIRE: begin
               if (period_good) begin
                  if ((good_q + RUN_ONE) == GOOD_N) begin
                     state_d = ST_HEALTHY;
                     good_d  = '0;
                  end else begin
                     good_d  = good_q + RUN_ONE;
                  end
               end else begin
                  state_d = ST_LOST;
                  good_d  = '0;
               end
            end
            ST_HEALTHY: begin
               if (!period_good) begin
                  if (BAD_CNT == 1) begin
                     state_d = ST_LOST;
                     bad_d   = '0;
                  end else begin
                     state_d = ST_SUSPECT;
                     bad_d   = RUN_ONE;
                  end
               end
            end
            ST_SUSPECT: begin
               if (period_good) begin
                  state_d = ST_HEALTHY;
                  bad_d   = '0;
               end else if ((bad_q + RUN_ONE) == BAD_N) begin
                  state_d = ST_LOST;
                  bad_d   = '0;
               end else begin
                  bad_d   = bad_q + RUN_ONE;
               end
            end
            default: begin
               state_d = ST_LOST;
               good_d  = '0;
               bad_d   = '0;
            end
         endcase
      end

      // io follows the next state so it moves on the same clk as the state.
      io_d   = (state_d == ST_HEALTHY) || (state_d == ST_SUSPECT);
      lost_d = io_q & ~io_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         edge_q   <= 1'b0;
         ref_q    <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
         pvalid_q <= 1'b0;
         state_q  <= ST_LOST;
         good_q   <= '0;
         bad_q    <= '0;
         io_q     <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         edge_q   <= edge_d;
         ref_q    <= ref_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pvalid_q <= pvalid_d;
         state_q  <= state_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         io_q     <= io_d;
         lost_q   <= lost_d;
      end
   end

   assign hb.io           = io_q;
   assign hb.lost_pulse   = lost_q;
   assign hb.period       = period_q;
   assign hb.period_valid = pvalid_q;
   assign state_o         = state_q;

endmodule

// File: doc/heartbeat_monitor.md
Name: heartbeat_monitor

Overview:
Upstream health stage for the switch-over logic. It qualifies one CPU heartbeat/PWM pin by edge-to-edge period measurement, with acquire/lose hysteresis, and drives the per-CPU health level `io` consumed by the A/B error-count and switch decision. One instance per CPU. It replaces the simple pulse-presence check with a period-window check.

Parameters:
- CNT_W, 24: width of the period counter and the `period` output.
- MIN_PERIOD, 90: shortest accepted period in clk cycles, inclusive.
- MAX_PERIOD, 110: longest accepted period in clk cycles, inclusive. Also the timeout threshold.
- GOOD_CNT, 3: consecutive good periods needed to assert `io`.
- BAD_CNT, 2: consecutive bad periods needed to deassert `io`.
- MIN_HIGH, 10: minimum pwm high time in clk cycles. Used only with HB_DUTY_CHECK_EN.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- pwm, input, 1: raw heartbeat pin, asynchronous to clk.
- io, output, 1: 1 = CPU healthy, 0 = CPU failed or not yet acquired.
- lost_pulse, output, 1: one-clk strobe on every 1->0 transition of `io`.
- period, output, CNT_W: last measured period in clk cycles.
- period_valid, output, 1: one-clk strobe when `period` updates.

Behaviour:
- Reset values: io=0, lost_pulse=0, period=0, period_valid=0, state=LOST, no reference edge held, sync flops=0.
- Input path: 2-FF synchronizer, then a registered previous value. A rising edge is detected 3 clk after the pin rises.
- Period counter:
  - Increments every clk while a reference edge is held.
  - Saturates at MAX_PERIOD+1.
  - On a detected edge: period = number of clk between this edge and the previous edge; period_valid pulses; counter restarts.
- First edge after reset or after timeout only establishes the reference. It is not judged and does not pulse period_valid.
- Good period: MIN_PERIOD <= P <= MAX_PERIOD. Any other P is bad.
- Timeout: counter reaches MAX_PERIOD+1 with no edge → immediate LOST from any state. The reference is dropped and the next edge re-arms measurement.
- FSM states, each with good_run/bad_run counters (width clog2 of max(GOOD_CNT, BAD_CNT)+1):
  - LOST (io=0): good edge → ACQUIRE with good_run=1. If GOOD_CNT=1, go to HEALTHY directly. Bad edge → stay in LOST.
  - ACQUIRE (io=0): good edge → good_run+1; when good_run reaches GOOD_CNT → HEALTHY. Bad edge → LOST with good_run=0.
  - HEALTHY (io=1): bad edge → SUSPECT with bad_run=1. If BAD_CNT=1, go to LOST directly. Good edge → stay in HEALTHY.
  - SUSPECT (io=1): good edge → HEALTHY with bad_run=0. Bad edge → bad_run+1; when bad_run reaches BAD_CNT → LOST.
- `io` is registered from the state. It changes in the same clk as the state transition, i.e. 1 clk after the edge-detect cycle.
- lost_pulse: asserted in the clk in which `io` goes 1->0, whether the cause is timeout or bad run. It is never asserted out of reset.
- Simultaneous edge and timeout in the same clk: the edge wins. P = MAX_PERIOD+1 is judged bad but does not drop the reference.
- Period arithmetic: unsigned. MAX_PERIOD+1 must fit in CNT_W. period_valid reports the unsaturated P.
- rst_n asserted mid-operation: all outputs return to reset values immediately, asynchronously. Re-acquisition needs GOOD_CNT+1 edges.

Optional Feature:
- Macro: HB_DUTY_CHECK_EN.
- Defined: a high-time counter runs while the synchronized pwm is 1 and clears on each rising edge. A period is good only if it is within the window and the last measured high time is >= MIN_HIGH. A pwm stuck high counts as timeout, as without the macro.
- Undefined: no high-time logic exists; MIN_HIGH is ignored; the period window alone decides good/bad.

Test Plan:
All scenarios use the default parameters.
1. Reset release, pwm period 100 clk, high 50 → io rises at the 4th rising edge + 4 clk. period_valid strobes with period=100 from the 2nd edge on.
2. Healthy, then pwm held low → io falls and lost_pulse pulses exactly 111 clk after the last detected edge.
3. Healthy, one period of 80 then 100s → io stays 1 (HEALTHY→SUSPECT→HEALTHY). Two consecutive periods of 80 → io falls at the 2nd bad edge and lost_pulse fires once.
4. Window boundaries from LOST:
   - periods 90, 110, 90 → io asserts.
   - periods 89, 111 → each judged bad; state remains LOST/ACQUIRE reset.
5. rst_n pulsed low in HEALTHY → io=0 and period=0 asynchronously. After release, io returns only after 4 good edges.
6. With HB_DUTY_CHECK_EN, period 100 with high time 5 → never acquires. Same bench without the macro → acquires on the 4th edge.
